// File: rtl/issue2_pkg.sv
// issue2_pkg
// Shared types for the issue2 dispatch buffer between Prefetch and ID.
//   entry_t      : one stored fetch pair (primary PC/instruction, issue2
//                  candidate and the allocator verdict)
//   phase_t      : presentation phase of the head entry
//   I2_PC_OFFSET : distance from the primary PC to the issue2 instruction
package issue2_pkg;

  localparam logic [31:0] I2_PC_OFFSET = 32'd4;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] pi_instr;
    logic [31:0] i2_instr;
    logic        i2_ok;
  } entry_t;

  // PH_WHOLE presents the full pair. PH_REMAINDER means the primary has
  // already been issued and the issue2 instruction is replayed on its own.
  typedef enum logic {
    PH_WHOLE     = 1'b0,
    PH_REMAINDER = 1'b1
  } phase_t;

endpackage

// File: rtl/issue2_pair_fifo.sv
// issue2_pair_fifo
// Circular pair storage with read/write pointers and an occupancy count.
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   flush        : empty the buffer; overrides any push/pop that cycle
//   push         : write push_entry at the tail (ignored when full)
//   pop          : retire the head entry (ignored when empty)
//   push_entry   : entry to store
//   head_entry   : entry at the read pointer (register-sourced)
//   empty, full  : occupancy flags derived from the count register
module issue2_pair_fifo
  import issue2_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   flush,
  input  logic   push,
  input  logic   pop,
  input  entry_t push_entry,
  output entry_t head_entry,
  output logic   empty,
  output logic   full
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(DEPTH);

  entry_t            mem [DEPTH];
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W:0]    count;
  logic              do_push;
  logic              do_pop;

  // Requests are qualified against the flags here so the caller can never
  // overrun or underrun the storage; a flush cancels both.
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;

  assign empty      = (count == '0);
  assign full       = (count == FULL_COUNT);
  assign head_entry = mem[rd_ptr];

  // Storage array is not reset: an entry is only observed once the count
  // says it has been written.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_entry;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two. A simultaneous
  // push and pop leaves the count unchanged while both pointers advance.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      if (do_push && !do_pop) begin
        count <= count + (PTR_W + 1)'(1);
      end else if (do_pop && !do_push) begin
        count <= count - (PTR_W + 1)'(1);
      end
    end
  end

endmodule

// File: rtl/issue2_pair_buffer.sv
// issue2_pair_buffer
// Registered dispatch buffer between Prefetch and ID of the dual-issue core.
// Stores up to DEPTH fetch pairs and presents the head to ID. When ID can
// take only a primary instruction, a granted pair is split and its issue2
// instruction is replayed afterwards as a standalone primary.
// Ports:
//   clk, rst                 : clock, synchronous active-high reset
//   flush_i                  : discard all stored entries (redirect)
//   f_valid_i / f_ready_o    : fetch handshake
//   f_pc_i, f_pi_instr_i,
//   f_i2_instr_i, f_i2_ok_i  : fetched pair and allocator verdict
//   id_valid_o / id_ready_i  : ID handshake
//   id_single_only_i         : ID accepts only a primary this cycle
//   id_pc_o, id_pi_instr_o,
//   id_i2_instr_o            : presented instructions
//   id_i2_valid_o            : issue2 slot valid (taken on handshake)
//   perf_pair_cnt_o          : dual-issued pairs (wraps)
//   perf_split_cnt_o         : split events (wraps)
module issue2_pair_buffer
  import issue2_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush_i,
  input  logic             f_valid_i,
  output logic             f_ready_o,
  input  logic [31:0]      f_pc_i,
  input  logic [31:0]      f_pi_instr_i,
  input  logic [31:0]      f_i2_instr_i,
  input  logic             f_i2_ok_i,
  output logic             id_valid_o,
  input  logic             id_ready_i,
  input  logic             id_single_only_i,
  output logic [31:0]      id_pc_o,
  output logic [31:0]      id_pi_instr_o,
  output logic [31:0]      id_i2_instr_o,
  output logic             id_i2_valid_o,
  output logic [CNT_W-1:0] perf_pair_cnt_o,
  output logic [CNT_W-1:0] perf_split_cnt_o
);

  entry_t           push_entry;
  entry_t           head;
  logic             empty;
  logic             full;
  logic             head_valid;
  logic             pop;
  logic             split;
  logic             pair_fire;
  phase_t           phase_q;
  phase_t           phase_d;
  logic [CNT_W-1:0] pair_cnt_q;
  logic [CNT_W-1:0] split_cnt_q;

  assign push_entry = '{pc: f_pc_i, pi_instr: f_pi_instr_i,
                        i2_instr: f_i2_instr_i, i2_ok: f_i2_ok_i};

  issue2_pair_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush_i),
    .push       (f_valid_i && f_ready_o),
    .pop        (pop),
    .push_entry (push_entry),
    .head_entry (head),
    .empty      (empty),
    .full       (full)
  );

  // Readiness looks only at occupancy, never at ID, so a full buffer stalls
  // fetch for one cycle even when ID drains the head at the same time.
  assign f_ready_o  = !full && !rst;
  assign head_valid = !empty;

  // Head phase register.
  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q <= PH_WHOLE;
    end else begin
      phase_q <= phase_d;
    end
  end

  // Decide what the ID handshake does to the head. A split keeps the entry
  // and moves to the remainder phase; everything else retires the entry.
  // Flush wins over any handshake in the same cycle.
  always_comb begin
    phase_d   = phase_q;
    pop       = 1'b0;
    split     = 1'b0;
    pair_fire = 1'b0;
    if (flush_i) begin
      phase_d = PH_WHOLE;
    end else if (head_valid && id_ready_i) begin
      if (phase_q == PH_REMAINDER) begin
        pop     = 1'b1;
        phase_d = PH_WHOLE;
      end else if (head.i2_ok && id_single_only_i) begin
        split   = 1'b1;
        phase_d = PH_REMAINDER;
      end else begin
        pop       = 1'b1;
        pair_fire = head.i2_ok;
      end
    end
  end

  // Presentation muxing. Outputs read zero while the buffer is empty so the
  // unreset storage never leaks onto the ID bus. Only id_i2_valid_o looks
  // at an input (id_single_only_i).
  always_comb begin
    id_valid_o    = head_valid;
    id_pc_o       = '0;
    id_pi_instr_o = '0;
    id_i2_instr_o = '0;
    id_i2_valid_o = 1'b0;
    if (head_valid) begin
      id_i2_instr_o = head.i2_instr;
      if (phase_q == PH_REMAINDER) begin
        id_pc_o       = head.pc + I2_PC_OFFSET;
        id_pi_instr_o = head.i2_instr;
      end else begin
        id_pc_o       = head.pc;
        id_pi_instr_o = head.pi_instr;
        id_i2_valid_o = head.i2_ok && !id_single_only_i;
      end
    end
  end

  // Performance counters wrap freely and are cleared only by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      pair_cnt_q  <= '0;
      split_cnt_q <= '0;
    end else begin
      if (pair_fire) begin
        pair_cnt_q <= pair_cnt_q + CNT_W'(1);
      end
      if (split) begin
        split_cnt_q <= split_cnt_q + CNT_W'(1);
      end
    end
  end

  assign perf_pair_cnt_o  = pair_cnt_q;
  assign perf_split_cnt_o = split_cnt_q;

endmodule

// File: doc/issue2_pair_buffer.md
# issue2_pair_buffer

Registered dispatch buffer between the Prefetch stage and the ID stage of the dual-issue core. Consumes each fetched primary instruction together with its issue2 candidate and the allocator verdict, stores up to DEPTH pairs, and presents them to ID with a valid/ready handshake. When ID can accept only one instruction, the buffer splits a pair and replays the issue2 instruction as a standalone primary. Dual-issue and split events are counted for performance monitoring.

## Interface
- DEPTH, 2, pair entries stored; power of two, ≥2
- CNT_W, 32, performance counter width
- clk  in  1  core clock
- rst  in  1  synchronous, active-high reset
- flush_i  in  1  discard all stored entries (branch/jump/exception redirect)
- f_valid_i  in  1  fetch presents a pair
- f_ready_o  out  1  buffer accepts a pair
- f_pc_i  in  32  PC of primary instruction
- f_pi_instr_i  in  32  primary instruction
- f_i2_instr_i  in  32  issue2 candidate (instruction at f_pc_i+4)
- f_i2_ok_i  in  1  issue2 allocation granted for this pair
- id_valid_o  out  1  head entry valid toward ID
- id_ready_i  in  1  ID consumes head this cycle
- id_single_only_i  in  1  ID accepts primary only this cycle
- id_pc_o  out  32  PC of presented primary
- id_pi_instr_o  out  32  presented primary instruction
- id_i2_instr_o  out  32  presented issue2 instruction
- id_i2_valid_o  out  1  issue2 slot is valid and taken on handshake
- perf_pair_cnt_o  out  CNT_W  dual-issued pairs
- perf_split_cnt_o  out  CNT_W  split events

## Operation
- Storage: circular buffer of DEPTH entries {pc, pi_instr, i2_instr, i2_ok}; rd_ptr, wr_ptr, count (0..DEPTH).
- Push: f_valid_i && f_ready_o. f_ready_o = (count < DEPTH) && !rst; independent of id_ready_i.
- Head phase FSM: PH_WHOLE (reset) → PH_REMAINDER on split; PH_REMAINDER → PH_WHOLE on head pop or flush.
- Presentation in PH_WHOLE: id_pc_o = pc, id_pi_instr_o = pi_instr, id_i2_valid_o = i2_ok && !id_single_only_i.
- Presentation in PH_REMAINDER: id_pc_o = pc+4 (32-bit wrap), id_pi_instr_o = i2_instr, id_i2_valid_o = 0.
- Handshake id_valid_o && id_ready_i:
  - PH_WHOLE, i2_ok, id_single_only_i=1: split — entry stays, phase → PH_REMAINDER, perf_split_cnt_o +1.
  - PH_WHOLE, i2_ok, id_single_only_i=0: pop, perf_pair_cnt_o +1.
  - PH_WHOLE, !i2_ok: pop.
  - PH_REMAINDER: pop, phase → PH_WHOLE.
- Push and pop in the same cycle: count unchanged, both pointers advance.
- Flush: count, pointers → 0, phase → PH_WHOLE; same-cycle push and pop are dropped; counters not touched.
- Counters wrap modulo 2^CNT_W; cleared only by rst.
- id_i2_instr_o is don't-care when id_i2_valid_o=0.

## Timing
- Fetch → ID latency 1 cycle: a pair pushed in cycle N is visible with id_valid_o=1 in N+1 when buffer empty.
- id_valid_o, id_pc_o, id_pi_instr_o, id_i2_instr_o derive from registers only; id_i2_valid_o is the only output combinationally dependent on an input (id_single_only_i).
- Full throughput: one pair per cycle sustained with id_ready_i=1 and DEPTH=2.
- Split costs exactly one extra ID cycle per pair.
- Reset values: id_valid_o=0, id_i2_valid_o=0, f_ready_o=0 during rst and 1 the cycle after, id_pc_o/instr outputs=0, counters=0, phase=PH_WHOLE.
- Reset mid-operation discards all entries, same as flush, and also clears counters.
- Full (count=DEPTH): f_ready_o=0 even if ID pops that cycle; f_ready_o returns to 1 next cycle.

## Structure
- issue2_pkg: entry struct (pc, pi_instr, i2_instr, i2_ok), phase enum {PH_WHOLE, PH_REMAINDER}, I2_PC_OFFSET=4.
- Sub-module issue2_pair_fifo: pointer/count storage with push/pop/flush. Phase FSM, presentation muxing and counters stay in the top module.

## Test plan
- Push pair pc=0x100, i2_ok=1, id_ready_i=1, id_single_only_i=0 → next cycle id_valid_o=1, id_pc_o=0x100, id_i2_valid_o=1; after handshake perf_pair_cnt_o=1, id_valid_o=0.
- Same pair with id_single_only_i=1 → cycle 1: PI issued, id_i2_valid_o=0, perf_split_cnt_o=1; cycle 2: id_pc_o=0x104, id_pi_instr_o=i2_instr, then pop.
- id_ready_i=0, push 3 pairs back-to-back → f_ready_o=0 after 2 accepted; third held; raise id_ready_i → pairs drain in order 0x100, 0x200, 0x300.
- Full buffer, PH_REMAINDER on head, assert flush_i with f_valid_i=1 → next cycle id_valid_o=0, f_ready_o=1, counters unchanged, pushed pair absent.
- Streaming 10 pairs with id_ready_i=1 and alternating i2_ok → one pair per cycle, perf_pair_cnt_o=5, no bubble.
- Counter wrap with CNT_W=4: 16 dual-issued pairs → perf_pair_cnt_o=0.
